// File: rtl/mem_access_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_initiator
//  Description : Load/store initiator for a word-only data memory. Sub-word
//                stores become read-modify-write sequences; loads are extended.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_initiator #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int DMEMWORDBITS   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reqValid,
    output logic                      reqReady,
    input  logic                      reqWrite,
    input  logic [1:0]                reqSize,
    input  logic                      reqSigned,
    input  logic [DATA_BIT_WIDTH-1:0] reqAddr,
    input  logic [DATA_BIT_WIDTH-1:0] reqData,
    output logic                      rspValid,
    output logic [DATA_BIT_WIDTH-1:0] rspData,
    output logic                      rspError,
    output logic                      wrMEM,
    output logic [DATA_BIT_WIDTH-1:0] memAddr,
    output logic [DATA_BIT_WIDTH-1:0] memDataOut,
    input  logic [DATA_BIT_WIDTH-1:0] memDataIn
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;
    localparam logic [1:0] c_SIZE_RSVD = 2'b11;

    logic [1:0]                r_state;
    logic                      r_write;
    logic [1:0]                r_size;
    logic                      r_signed;
    logic [DMEMWORDBITS-1:0]   r_lane;
    logic [15:0]               r_data;
    logic [DATA_BIT_WIDTH-1:0] r_rsp_data;
    logic                      r_rsp_error;
    logic [DATA_BIT_WIDTH-1:0] r_mem_addr;
    logic [DATA_BIT_WIDTH-1:0] r_mem_data;

    logic                      w_accept;
    logic                      w_req_error;
    logic [DATA_BIT_WIDTH-1:0] w_req_word_addr;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic [DATA_BIT_WIDTH-1:0] w_load_data;
    logic [DATA_BIT_WIDTH-1:0] w_merged;

    // Ready is gated by reset so nothing is accepted while the unit is held.
    assign reqReady   = reset && (r_state == c_IDLE);
    assign w_accept   = reqValid && reqReady;
    assign wrMEM      = (r_state == c_WRITE);
    assign rspValid   = (r_state == c_RESP);
    assign rspData    = r_rsp_data;
    assign rspError   = r_rsp_error;
    assign memAddr    = r_mem_addr;
    assign memDataOut = r_mem_data;

    assign w_req_error = (reqSize == c_SIZE_RSVD)
                      || ((reqSize == c_SIZE_HALF) && reqAddr[0])
                      || ((reqSize == c_SIZE_WORD) && (reqAddr[1:0] != 2'b00));

    assign w_req_word_addr = {reqAddr[DATA_BIT_WIDTH-1:DMEMWORDBITS], {DMEMWORDBITS{1'b0}}};

    assign w_byte = memDataIn[{r_lane, 3'b000} +: 8];
    assign w_half = memDataIn[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = memDataIn;
        case (r_size)
            c_SIZE_BYTE: w_load_data = {{(DATA_BIT_WIDTH-8){r_signed & w_byte[7]}}, w_byte};
            c_SIZE_HALF: w_load_data = {{(DATA_BIT_WIDTH-16){r_signed & w_half[15]}}, w_half};
            default:     w_load_data = memDataIn;
        endcase
    end

    // Only byte and halfword stores reach the merge path.
    always_comb begin
        w_merged = memDataIn;
        if (r_size == c_SIZE_BYTE) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_data[7:0];
        end else begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_data[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_lane      <= '0;
            r_data      <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_write  <= reqWrite;
                        r_size   <= reqSize;
                        r_signed <= reqSigned;
                        r_lane   <= reqAddr[DMEMWORDBITS-1:0];
                        r_data   <= reqData[15:0];
                        if (w_req_error) begin
                            r_rsp_error <= 1'b1;
                            r_rsp_data  <= '0;
                            r_state     <= c_RESP;
                        end else if (reqWrite && (reqSize == c_SIZE_WORD)) begin
                            r_mem_addr <= w_req_word_addr;
                            r_mem_data <= reqData;
                            r_state    <= c_WRITE;
                        end else begin
                            r_mem_addr <= w_req_word_addr;
                            r_state    <= c_READ;
                        end
                    end
                end
                c_READ: begin
                    if (r_write) begin
                        r_mem_data <= w_merged;
                        r_state    <= c_WRITE;
                    end else begin
                        r_rsp_data <= w_load_data;
                        r_state    <= c_RESP;
                    end
                end
                c_WRITE: begin
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    r_rsp_data  <= '0;
                    r_rsp_error <= 1'b0;
                    r_state     <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_initiator
//  Description : Self-checking bench for mem_access_initiator with a word memory
//                and a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid, reqReady, reqWrite, reqSigned;
    logic [1:0]  reqSize;
    logic [31:0] reqAddr, reqData;
    logic        rspValid, rspError, wrMEM;
    logic [31:0] rspData, memAddr, memDataOut, memDataIn;

    bit [31:0] mem     [64];
    bit [31:0] ref_mem [64];
    int        n_tests = 0;
    int        n_fail  = 0;
    logic [31:0] last_rsp;

    always #5 clk = ~clk;

    mem_access_initiator #(.DATA_BIT_WIDTH(32), .DMEMWORDBITS(2)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
        .rspValid(rspValid), .rspData(rspData), .rspError(rspError),
        .wrMEM(wrMEM), .memAddr(memAddr), .memDataOut(memDataOut), .memDataIn(memDataIn)
    );

    assign memDataIn = mem[memAddr[7:2]];
    always @(posedge clk) if (wrMEM) mem[memAddr[7:2]] <= memDataOut;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: what the request should return, how long it takes, what word lands in memory.
    task automatic model(input bit w, input bit [1:0] sz, input bit sg, input bit [31:0] a,
                         input bit [31:0] d, output bit [31:0] rsp, output bit err,
                         output int lat, output bit [31:0] wdata);
        bit [31:0] word, mask;
        int sh;
        rsp = 0; err = 0; wdata = 0; lat = 0;
        word = ref_mem[a[7:2]];
        sh = 8 * int'(a[1:0]);
        if (sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0)) begin
            err = 1; lat = 1;
        end else if (!w) begin
            lat = 2;
            word = word >> sh;
            if (sz == 0) begin
                rsp = word & 32'hFF;
                if (sg && rsp[7]) rsp = rsp | 32'hFFFFFF00;
            end else if (sz == 1) begin
                rsp = word & 32'hFFFF;
                if (sg && rsp[15]) rsp = rsp | 32'hFFFF0000;
            end else begin
                rsp = word;
            end
        end else begin
            if (sz == 2) begin
                wdata = d; lat = 2;
            end else begin
                mask = (sz == 0) ? 32'hFF : 32'hFFFF;
                wdata = (word & ~(mask << sh)) | ((d & mask) << sh);
                lat = 3;
            end
            ref_mem[a[7:2]] = wdata;
        end
    endtask

    task automatic do_req(input bit w, input bit [1:0] sz, input bit sg,
                          input bit [31:0] a, input bit [31:0] d);
        bit [31:0] ersp, ewd;
        bit        eerr;
        int        elat, lat, nwr;
        check("ready_idle", {31'd0, reqReady}, 32'd1);
        model(w, sz, sg, a, d, ersp, eerr, elat, ewd);
        reqValid = 1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqData = d;
        tick;
        reqValid = 0;
        lat = 1; nwr = 0;
        while (!rspValid && lat < 8) begin
            check("busy_ready", {31'd0, reqReady}, 32'd0);
            if (wrMEM) begin
                nwr++;
                check("wr_addr", memAddr, a & 32'hFFFFFFFC);
                check("wr_data", memDataOut, ewd);
            end
            tick;
            lat++;
        end
        if (wrMEM) nwr++;
        last_rsp = rspData;
        check("rsp_valid", {31'd0, rspValid}, 32'd1);
        check("latency", lat, elat);
        check("rsp_data", rspData, ersp);
        check("rsp_err", {31'd0, rspError}, {31'd0, eerr});
        check("n_writes", nwr, (w && !eerr) ? 32'd1 : 32'd0);
        tick;
        check("rsp_drop", {31'd0, rspValid}, 32'd0);
        check("rsp_data_idle", rspData, 32'd0);
    endtask

    initial begin
        bit [1:0]  sz;
        bit [31:0] ersp, ewd;
        bit        eerr, acc;
        int        elat, k, idx, cycles;
        bit [31:0] qd[$];
        bit        qe[$];

        reset = 0; reqValid = 0; reqWrite = 0; reqSize = 0; reqSigned = 0;
        reqAddr = 0; reqData = 0;
        tick; tick;
        check("rst_ready", {31'd0, reqReady}, 32'd0);
        check("rst_rspvalid", {31'd0, rspValid}, 32'd0);
        check("rst_wrmem", {31'd0, wrMEM}, 32'd0);
        check("rst_memaddr", memAddr, 32'd0);
        check("rst_memdata", memDataOut, 32'd0);
        check("rst_rspdata", rspData, 32'd0);
        reset = 1;
        tick;

        // Directed scenarios
        do_req(1, 2, 0, 32'h10, 32'hDEADBEEF);
        do_req(0, 2, 0, 32'h10, 32'h0);
        check("plan_word_load", last_rsp, 32'hDEADBEEF);
        do_req(1, 2, 0, 32'h20, 32'h80FF7F01);
        do_req(0, 0, 1, 32'h22, 32'h0);
        check("plan_sbyte", last_rsp, 32'hFFFFFFFF);
        do_req(0, 0, 0, 32'h23, 32'h0);
        check("plan_ubyte", last_rsp, 32'h00000080);
        do_req(0, 1, 1, 32'h22, 32'h0);
        check("plan_shalf", last_rsp, 32'hFFFF80FF);
        do_req(1, 2, 0, 32'h30, 32'h11223344);
        do_req(1, 0, 0, 32'h31, 32'h000000AA);
        check("plan_rmw_byte", mem[12], 32'h1122AA44);
        do_req(1, 1, 0, 32'h32, 32'h0000BEEF);
        check("plan_rmw_half", mem[12], 32'hBEEFAA44);
        do_req(0, 2, 0, 32'h42, 32'h0);
        do_req(1, 1, 0, 32'h41, 32'h12345678);

        // Randomized traffic over a small window so words get reused
        for (int i = 0; i < 120; i++) begin
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 63)), $urandom);
        end
        for (int i = 0; i < 16; i++) check("mem_final", mem[i], ref_mem[i]);

        // Abort a sub-word store while it is writing
        reqValid = 1; reqWrite = 1; reqSize = 0; reqSigned = 0; reqAddr = 32'h35; reqData = 32'h5A;
        tick;
        reqValid = 0;
        k = 0;
        while (!wrMEM && k < 5) begin tick; k++; end
        check("abort_saw_wr", {31'd0, wrMEM}, 32'd1);
        reset = 0;
        #1;
        check("abort_wr_drop", {31'd0, wrMEM}, 32'd0);
        check("abort_ready_low", {31'd0, reqReady}, 32'd0);
        tick; tick;
        reset = 1;
        tick;
        check("abort_ready", {31'd0, reqReady}, 32'd1);
        check("abort_no_rsp", {31'd0, rspValid}, 32'd0);
        tick;
        check("abort_no_rsp2", {31'd0, rspValid}, 32'd0);
        check("abort_mem", mem[13], ref_mem[13]);

        // Back-to-back: reqValid held high across a stream of requests
        idx = 0; cycles = 0;
        reqValid = 1; reqWrite = 1'($urandom_range(0, 1)); reqSize = 2'($urandom_range(0, 3));
        reqSigned = 1'($urandom_range(0, 1)); reqAddr = 32'($urandom_range(0, 63)); reqData = $urandom;
        while ((idx < 12 || qd.size() > 0) && cycles < 200) begin
            check("b2b_ready", {31'd0, reqReady}, (qd.size() == 0) ? 32'd1 : 32'd0);
            if (rspValid) begin
                if (qd.size() == 0) begin
                    check("b2b_spurious", 32'd1, 32'd0);
                end else begin
                    check("b2b_data", rspData, qd.pop_front());
                    check("b2b_err", {31'd0, rspError}, {31'd0, qe.pop_front()});
                end
            end
            acc = reqReady && reqValid;
            if (acc) begin
                model(reqWrite, reqSize, reqSigned, reqAddr, reqData, ersp, eerr, elat, ewd);
                qd.push_back(ersp);
                qe.push_back(eerr);
            end
            tick;
            cycles++;
            if (acc) begin
                idx++;
                if (idx < 12) begin
                    reqWrite = 1'($urandom_range(0, 1)); reqSize = 2'($urandom_range(0, 3));
                    reqSigned = 1'($urandom_range(0, 1)); reqAddr = 32'($urandom_range(0, 63));
                    reqData = $urandom;
                end else begin
                    reqValid = 0;
                end
            end
        end
        check("b2b_done", cycles < 200 ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 16; i++) check("b2b_mem", mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_initiator.md
Name: mem_access_initiator

Overview:
- Load/store initiator that drives the data-memory bus (wrMEM/addr/dataIn/dataOut) on behalf of a multi-cycle core.
- Accepts byte, halfword and word requests over a valid/ready handshake and returns a one-cycle response.
- Converts sub-word stores into read-modify-write sequences, because the memory side is word-only.
- Performs sign or zero extension on loads and flags misaligned accesses without touching memory.

Parameters:
- DATA_BIT_WIDTH, 32, data and address width. Only 32 is supported: byte-lane logic is fixed at 4 lanes.
- DMEMWORDBITS, 2, low address bits selecting the byte within a word.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- reqValid  input  1  request present
- reqReady  output  1  unit can accept a request this cycle
- reqWrite  input  1  1=store, 0=load
- reqSize  input  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as error)
- reqSigned  input  1  loads only: 1=sign-extend, 0=zero-extend
- reqAddr  input  32  byte address
- reqData  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
- rspValid  output  1  response strobe, exactly one cycle
- rspData  output  32  extended load data; 0 for stores and errors
- rspError  output  1  misaligned or reserved-size request; valid with rspValid
- wrMEM  output  1  memory write enable
- memAddr  output  32  word-aligned memory address
- memDataOut  output  32  memory write data
- memDataIn  input  32  memory read data; combinational from memAddr, same cycle

Behaviour:
- Reset (reset=0), asynchronous:
  - state=IDLE; all request registers cleared.
  - reqReady=0, rspValid=0, rspData=0, rspError=0, wrMEM=0, memAddr=0, memDataOut=0.
  - reqReady is gated low while reset=0. After reset release it is 1 whenever state=IDLE.
- States:
  - IDLE: reqReady=1. Accept when reqValid&&reqReady; latch write, size, signed, addr and data. Next state:
    - error request -> RESP with error=1
    - load -> READ
    - word store -> WRITE
    - sub-word store -> READ
  - READ: memAddr=addr with low 2 bits cleared; wrMEM=0. Capture memDataIn at the clock edge.
    - Load: extract, extend, -> RESP.
    - Sub-word store: hold captured word, -> WRITE.
  - WRITE: wrMEM=1 for exactly one cycle; memAddr=aligned addr.
    - Word store: memDataOut=reqData.
    - Sub-word store: memDataOut=captured word with the addressed lane(s) replaced.
    - -> RESP.
  - RESP: rspValid=1 for one cycle with rspData/rspError; -> IDLE. No backpressure on the response.
- Error conditions (no memory access, wrMEM stays 0):
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - size=11
- Byte lanes are little-endian: lane k = bits [8k+7:8k].
  - Byte access uses lane addr[1:0].
  - Halfword access uses lanes addr[1]*2 and addr[1]*2+1.
- Extension: a signed load replicates the top bit of the extracted byte or halfword into the upper bits; an unsigned load zero-fills.
- Latency, accept edge to rspValid:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Outputs in non-driving states:
  - memAddr and memDataOut hold their last values outside READ/WRITE.
  - rspData and rspError are 0 whenever rspValid=0.
- reqValid while busy: ignored (reqReady=0); the unit does not latch it. The requester must hold it.
- Reset mid-operation: the sequence is abandoned immediately.
  - wrMEM drops asynchronously.
  - A pending sub-word store produces no write and no response.

Test Plan:
- Reset mid-op: assert reset=0 during WRITE of a sub-word store -> wrMEM falls before the next edge. After release, reqReady=1 and no rspValid for the aborted request.
- Word store then load at addr 0x10: store reqData=0xDEADBEEF -> wrMEM=1 one cycle with memAddr=0x10, memDataOut=0xDEADBEEF. Load -> rspData=0xDEADBEEF two cycles after accept.
- Signed and unsigned byte loads: memory word 0x80FF7F01 at 0x20. Load byte 0x22 signed -> rspData=0xFFFFFFFF. Unsigned byte 0x23 -> 0x00000080. Signed halfword 0x22 -> 0xFFFF80FF.
- Sub-word store RMW: memory 0x11223344 at 0x30. Store byte 0xAA to 0x31 -> READ then WRITE of 0x1122AA44, rspValid 3 cycles after accept. Halfword 0xBEEF to 0x32 -> 0xBEEFAA44.
- Misalignment: word load at 0x42 and halfword store at 0x41 -> rspValid and rspError=1 one cycle after accept, rspData=0, wrMEM never asserted.
- Handshake: hold reqValid high with back-to-back requests -> reqReady low in READ/WRITE/RESP. Each request is accepted only in IDLE, and response order matches request order.
